// File: rtl/ecc_pkg.sv
// Types shared between the ECC encoder/decoder top and its downstream consumers.
package ecc_pkg;

   localparam int ECC_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_SINGLE  = 2'b01,
      ERR_DOUBLE  = 2'b10,
      ERR_INVALID = 2'b11
   } ecc_err_e;

   typedef struct packed {
      ecc_err_e                  err;
      logic [ECC_DATA_WIDTH-1:0] data;
   } ecc_result_t;

   // Both double and invalid results count as uncorrectable.
   function automatic logic is_uncorrectable(input ecc_err_e e);
      return (e == ERR_DOUBLE) || (e == ERR_INVALID);
   endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating up-counter with a synchronous clear; the clear takes priority over increment.
module ecc_sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != {WIDTH{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ecc_result_buffer.sv
// Show-ahead result FIFO behind the ECC top, with sticky overflow and saturating
// error-class statistics.
module ecc_result_buffer
   import ecc_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16,
   localparam int PW        = $clog2(DEPTH),
   localparam int LW        = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  res_valid_in,
   input  logic [DATA_WIDTH-1:0] res_data_in,
   input  logic [1:0]            res_err_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [1:0]            out_err,
   output logic                  full,
   output logic                  empty,
   output logic [LW-1:0]         level,
   output logic                  overflow,
   input  logic                  clr_stats,
   output logic [CNT_WIDTH-1:0]  cnt_total,
   output logic [CNT_WIDTH-1:0]  cnt_single,
   output logic [CNT_WIDTH-1:0]  cnt_double
);

   typedef struct packed {
      ecc_err_e              err;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_ptr;
   logic            pop;
   logic            push_ok;
   logic            drop;
   ecc_err_e        err_in;

   assign err_in    = ecc_err_e'(res_err_in);
   assign empty     = (level == '0);
   assign full      = (level == LW'(DEPTH));
   assign out_valid = !empty;
   assign pop       = out_valid && out_ready;
   // A full FIFO still takes a new result when the head leaves in the same cycle.
   assign push_ok   = res_valid_in && (!full || pop);
   assign drop      = res_valid_in && full && !pop;

   assign out_data  = empty ? '0 : mem[rd_ptr].data;
   assign out_err   = empty ? 2'b00 : mem[rd_ptr].err;

   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         mem[wr_ptr] <= '{err: err_in, data: res_data_in};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (clr_stats)  overflow <= 1'b0;
         else if (drop)  overflow <= 1'b1;
      end
   end

   ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_total (
      .clk (clk),
      .rst (rst),
      .clr (clr_stats),
      .inc (push_ok),
      .cnt (cnt_total)
   );

   ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_single (
      .clk (clk),
      .rst (rst),
      .clr (clr_stats),
      .inc (push_ok && (err_in == ERR_SINGLE)),
      .cnt (cnt_single)
   );

   ecc_sat_counter #(.WIDTH(CNT_WIDTH)) u_cnt_double (
      .clk (clk),
      .rst (rst),
      .clr (clr_stats),
      .inc (push_ok && is_uncorrectable(err_in)),
      .cnt (cnt_double)
   );

endmodule

// File: tb/tb_ecc_result_buffer.sv
// Directed bench for ecc_result_buffer: default instance plus a CNT_WIDTH=4 instance
// sharing the same stimulus to reach counter saturation quickly.
module tb_ecc_result_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic        res_valid_in;
   logic [31:0] res_data_in;
   logic [1:0]  res_err_in;
   logic        out_ready;
   logic        clr_stats;

   logic        out_valid, full, empty, overflow;
   logic [31:0] out_data;
   logic [1:0]  out_err;
   logic [2:0]  level;
   logic [15:0] cnt_total, cnt_single, cnt_double;

   logic        out_valid4, full4, empty4, overflow4;
   logic [31:0] out_data4;
   logic [1:0]  out_err4;
   logic [2:0]  level4;
   logic [3:0]  cnt_total4, cnt_single4, cnt_double4;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ecc_result_buffer dut (
      .clk(clk), .rst(rst), .res_valid_in(res_valid_in), .res_data_in(res_data_in),
      .res_err_in(res_err_in), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_err(out_err), .full(full), .empty(empty),
      .level(level), .overflow(overflow), .clr_stats(clr_stats),
      .cnt_total(cnt_total), .cnt_single(cnt_single), .cnt_double(cnt_double)
   );

   ecc_result_buffer #(.CNT_WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .res_valid_in(res_valid_in), .res_data_in(res_data_in),
      .res_err_in(res_err_in), .out_valid(out_valid4), .out_ready(out_ready),
      .out_data(out_data4), .out_err(out_err4), .full(full4), .empty(empty4),
      .level(level4), .overflow(overflow4), .clr_stats(clr_stats),
      .cnt_total(cnt_total4), .cnt_single(cnt_single4), .cnt_double(cnt_double4)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [31:0] d, input logic [1:0] e);
      res_valid_in = 1'b1;
      res_data_in  = d;
      res_err_in   = e;
      tick();
      res_valid_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; res_valid_in = 1'b0; res_data_in = '0; res_err_in = '0;
      out_ready = 1'b0; clr_stats = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // reset state
      chk("rst_empty", 32'(empty), 1);
      chk("rst_full", 32'(full), 0);
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_level", 32'(level), 0);
      chk("rst_ovf", 32'(overflow), 0);
      chk("rst_cnt_total", 32'(cnt_total), 0);
      chk("rst_data", out_data, 0);
      chk("rst_err", 32'(out_err), 0);

      // three results, reader stalled
      push(32'h0000_00AA, 2'b00);
      chk("lat_valid", 32'(out_valid), 1);
      chk("lat_data", out_data, 32'hAA);
      push(32'h0000_00BB, 2'b01);
      push(32'h0000_00CC, 2'b10);
      chk("t1_level", 32'(level), 3);
      chk("t1_head", out_data, 32'hAA);
      chk("t1_head_err", 32'(out_err), 0);
      chk("t1_total", 32'(cnt_total), 3);
      chk("t1_single", 32'(cnt_single), 1);
      chk("t1_double", 32'(cnt_double), 1);

      // drain in order
      out_ready = 1'b1;
      tick();
      chk("t2_pop1", out_data, 32'hBB);
      chk("t2_pop1_err", 32'(out_err), 1);
      tick();
      chk("t2_pop2", out_data, 32'hCC);
      chk("t2_pop2_err", 32'(out_err), 2);
      tick();
      chk("t2_empty", 32'(empty), 1);
      chk("t2_empty_data", out_data, 0);
      chk("t2_no_ovf", 32'(overflow), 0);
      out_ready = 1'b0;
      tick();
      chk("t2_ready_empty_level", 32'(level), 0);

      // fill to full, fifth is dropped
      push(32'h11, 2'b00);
      push(32'h22, 2'b01);
      push(32'h33, 2'b11);
      chk("t3_not_full", 32'(full), 0);
      push(32'h44, 2'b00);
      chk("t3_full", 32'(full), 1);
      chk("t3_level4", 32'(level), 4);
      chk("t3_ovf_before", 32'(overflow), 0);
      push(32'h55, 2'b10);
      chk("t3_ovf", 32'(overflow), 1);
      chk("t3_level_drop", 32'(level), 4);
      chk("t3_total", 32'(cnt_total), 7);
      chk("t3_single", 32'(cnt_single), 2);
      chk("t3_double", 32'(cnt_double), 2);
      chk("t3_head", out_data, 32'h11);
      tick();
      chk("t3_ovf_sticky", 32'(overflow), 1);

      // clear stats; FIFO untouched
      clr_stats = 1'b1;
      tick();
      clr_stats = 1'b0;
      chk("clr_ovf", 32'(overflow), 0);
      chk("clr_total", 32'(cnt_total), 0);
      chk("clr_double", 32'(cnt_double), 0);
      chk("clr_level", 32'(level), 4);
      chk("clr_head", out_data, 32'h11);

      // full with push and pop together
      out_ready = 1'b1;
      push(32'h66, 2'b01);
      chk("t4_level", 32'(level), 4);
      chk("t4_head", out_data, 32'h22);
      chk("t4_head_err", 32'(out_err), 1);
      chk("t4_ovf", 32'(overflow), 0);
      chk("t4_total", 32'(cnt_total), 1);
      tick();
      chk("t4_d33", out_data, 32'h33);
      chk("t4_e33", 32'(out_err), 3);
      tick();
      chk("t4_d44", out_data, 32'h44);
      tick();
      chk("t4_d66", out_data, 32'h66);
      tick();
      chk("t4_drained", 32'(empty), 1);
      out_ready = 1'b0;

      // saturation on the 4-bit instance
      rst = 1'b1;
      tick();
      rst = 1'b0;
      out_ready = 1'b1;
      push(32'd1, 2'b01);
      chk("nobypass_level", 32'(level), 1);
      chk("nobypass_data", out_data, 1);
      for (int i = 2; i <= 17; i++) push(32'(i), 2'b01);
      chk("sat_single4", 32'(cnt_single4), 15);
      chk("sat_total4", 32'(cnt_total4), 15);
      chk("sat_double4", 32'(cnt_double4), 0);
      chk("sat_total16", 32'(cnt_total), 17);
      chk("sat_level", 32'(level4), 1);
      chk("sat_head", out_data4, 17);

      // clear coincident with push: clear wins, push still lands
      clr_stats = 1'b1;
      push(32'hDEAD_BEEF, 2'b01);
      clr_stats = 1'b0;
      out_ready = 1'b0;
      chk("clrpush_total4", 32'(cnt_total4), 0);
      chk("clrpush_single4", 32'(cnt_single4), 0);
      chk("clrpush_total", 32'(cnt_total), 0);
      chk("clrpush_ovf", 32'(overflow4), 0);
      chk("clrpush_data", out_data4, 32'hDEAD_BEEF);
      chk("clrpush_level", 32'(level4), 1);

      // reset mid-operation with a coincident result
      push(32'h77, 2'b10);
      chk("rstmid_level_pre", 32'(level), 2);
      rst = 1'b1;
      push(32'h88, 2'b01);
      rst = 1'b0;
      chk("rstmid_empty", 32'(empty), 1);
      chk("rstmid_level", 32'(level), 0);
      chk("rstmid_valid", 32'(out_valid), 0);
      chk("rstmid_total", 32'(cnt_total), 0);
      chk("rstmid_double", 32'(cnt_double), 0);
      tick();
      chk("rstmid_ignored", 32'(level), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
